// File: rtl/mips_rf_pkg.sv
// Shared register-file types for the MIPS write path.
package mips_rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } rf_wr_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rf_aux_fifo.sv
// Auxiliary write buffer: entries carry a live bit that a younger primary
// write to the same register can clear; dead entries still occupy a slot.
module rf_aux_fifo
  import mips_rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  rf_wr_t                push_entry,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_reg,
  output rf_wr_t                head,
  output logic                  head_valid,
  output logic                  head_live,
  output logic                  full,
  output logic [NUM_REGS-1:0]   pending
);
  localparam int AW = $clog2(DEPTH);

  rf_wr_t           mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign wr_idx     = wr_ptr[AW-1:0];
  assign rd_idx     = rd_ptr[AW-1:0];
  assign head_valid = (wr_ptr != rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign head       = mem[rd_idx];
  assign head_live  = head_valid && live[rd_idx];

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_entry;
  end

  // Kill first, then push, so a same-cycle push (the younger write) stays live.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      live   <= '0;
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++)
          if (mem[i].rd == kill_reg) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rd_idx] <= 1'b0;
        rd_ptr       <= rd_ptr + (AW+1)'(1);
      end
      if (push) begin
        live[wr_idx] <= 1'b1;
        wr_ptr       <= wr_ptr + (AW+1)'(1);
      end
    end
  end

  // Live bits are cleared on pop, so only occupied slots contribute.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i]) pending = pending | reg_onehot(mem[i].rd);
    pending[0] = 1'b0;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, buffered
// auxiliary returns drain in free cycles, with a one-cycle starvation yield.
module rf_write_arbiter
  import mips_rf_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [REG_ADDR_W-1:0] aux_reg,
  input  logic [DATA_W-1:0]     aux_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0]     Write_data,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  wb_stall,
  output logic                  err
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]       wait_cnt, wait_nxt;
  logic                stall_q, err_q;
  logic                full, head_valid, head_live;
  logic                push, pop, wb_req, grant_head, grant_wb;
  rf_wr_t              head, push_entry;
  logic [NUM_REGS-1:0] fifo_pending;

  assign aux_ready  = !reset && !full;
  assign push       = aux_valid && aux_ready && (aux_reg != ZERO_REG);
  assign push_entry = '{rd: aux_reg, data: aux_data};

  // A primary request presented during a stall cycle is dropped (and flagged).
  assign wb_req     = wb_en && (wb_reg != ZERO_REG) && !stall_q;
  assign grant_head = head_live && (stall_q || !wb_req);
  assign grant_wb   = wb_req && !grant_head;
  assign pop        = grant_head || (head_valid && !head_live);

  rf_aux_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (grant_wb),
    .kill_reg   (wb_reg),
    .head       (head),
    .head_valid (head_valid),
    .head_live  (head_live),
    .full       (full),
    .pending    (fifo_pending)
  );

  always_comb begin
    RegWrite       = 1'b0;
    Write_register = ZERO_REG;
    Write_data     = '0;
    if (!reset) begin
      if (grant_head) begin
        RegWrite       = 1'b1;
        Write_register = head.rd;
        Write_data     = head.data;
      end else if (grant_wb) begin
        RegWrite       = 1'b1;
        Write_register = wb_reg;
        Write_data     = wb_data;
      end
    end
  end

  // Without a pop, a non-empty FIFO has a live head that lost the port.
  always_comb begin
    wait_nxt = wait_cnt;
    if (pop || !head_valid) wait_nxt = '0;
    else                    wait_nxt = wait_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      stall_q  <= (wait_nxt == CW'(STARVE_LIMIT));
      err_q    <= err_q | (wb_en & stall_q);
    end
  end

  assign wb_stall = stall_q && !reset;
  assign err      = err_q && !reset;
  assign pending  = reset ? '0 : fifo_pending;
endmodule
